// File: rtl/femto_pkg.sv
// Shared definitions for the shift issue path: shifter type codes, funct3
// encodings, and the issue entry carried between the issue stage and the shifter.
// Entry fields are sized for the widest datapath (RV32I) and narrowed at the ports.
package femto_pkg;

  localparam logic [1:0] SHIFT_SRL = 2'd0;
  localparam logic [1:0] SHIFT_SLL = 2'd1;
  localparam logic [1:0] SHIFT_SRA = 2'd2;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  // "type" is a keyword, so the shifter type field is named shtype.
  typedef struct packed {
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  shtype;
    logic [4:0]  rd;
    logic        illegal;
  } issue_entry_t;

  localparam issue_entry_t ENTRY_RESET = '{
    a:       32'd0,
    shamt:   5'd0,
    shtype:  SHIFT_SLL,
    rd:      5'd0,
    illegal: 1'b0
  };

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of a shift instruction into shifter controls.
// Ports:
//   i_funct3, i_funct7b5 : instruction function fields
//   i_is_imm             : 1 = immediate form (SLLI/SRLI/SRAI)
//   i_imm                : I-type immediate
//   i_rs2                : register shift amount source
//   o_shamt              : shift amount (low SW bits of imm or rs2)
//   o_type               : shifter type code (SHIFT_SRL/SLL/SRA)
//   o_illegal            : encoding is illegal
module shift_decode
  import femto_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SW   = $clog2(XLEN)
) (
  input  logic [2:0]      i_funct3,
  input  logic            i_funct7b5,
  input  logic            i_is_imm,
  input  logic [11:0]     i_imm,
  input  logic [XLEN-1:0] i_rs2,
  output logic [SW-1:0]   o_shamt,
  output logic [1:0]      o_type,
  output logic            o_illegal
);

  logic w_bad_f3;
  logic w_imm_hi;
  logic w_unused_bits;

  always_comb begin
    o_type   = SHIFT_SLL;
    w_bad_f3 = 1'b0;
    case (i_funct3)
      F3_SLL:  o_type = SHIFT_SLL;
      F3_SRX:  o_type = i_funct7b5 ? SHIFT_SRA : SHIFT_SRL;
      default: w_bad_f3 = 1'b1;
    endcase
  end

  // Immediate bits above the shamt field (up to bit 9) must be zero.
  assign w_imm_hi  = (i_imm[9:0] >> SW) != 10'd0;
  assign o_illegal = w_bad_f3 |
                     (i_is_imm & (w_imm_hi | ((i_funct3 == F3_SLL) & i_funct7b5)));
  assign o_shamt   = i_is_imm ? i_imm[SW-1:0] : i_rs2[SW-1:0];

  // Upper rs2 bits and imm[11:10] take no part in the decode.
  assign w_unused_bits = ^{i_rs2[XLEN-1:SW], i_imm[11:10]};

endmodule

// File: rtl/shift_issue_stage.sv
// Registered issue stage in front of the barrel shifter. Decodes shift
// instructions and holds up to two entries (main + skid) so that in_ready can be
// a plain register while still sustaining one transfer per cycle.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : synchronous kill of all held entries
//   in_*          : upstream valid/ready and decoded instruction fields
//   out_*         : downstream valid/ready and shifter operands (from main entry)
module shift_issue_stage
  import femto_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned SW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [11:0]     in_imm,
  input  logic            in_is_imm,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [SW-1:0]   out_shamt,
  output logic [1:0]      out_type,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  // Encoding is {main_v, skid_v}.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b10,
    StTwo   = 2'b11
  } state_e;

  state_e       r_state, w_state_d;
  issue_entry_t r_main, w_main_d;
  issue_entry_t r_skid, w_skid_d;
  logic         r_in_ready, w_in_ready_d;

  logic [SW-1:0] w_shamt;
  logic [1:0]    w_type;
  logic          w_illegal;
  logic          w_accept;
  issue_entry_t  w_in_entry;

  shift_decode #(
    .XLEN (XLEN),
    .SW   (SW)
  ) u_decode (
    .i_funct3   (in_funct3),
    .i_funct7b5 (in_funct7b5),
    .i_is_imm   (in_is_imm),
    .i_imm      (in_imm),
    .i_rs2      (in_rs2),
    .o_shamt    (w_shamt),
    .o_type     (w_type),
    .o_illegal  (w_illegal)
  );

  assign w_accept   = in_valid & r_in_ready;
  assign w_in_entry = '{
    a:       32'(in_rs1),
    shamt:   5'(w_shamt),
    shtype:  w_type,
    rd:      in_rd,
    illegal: w_illegal
  };

  always_comb begin
    w_state_d = r_state;
    w_main_d  = r_main;
    w_skid_d  = r_skid;
    case (r_state)
      StEmpty: begin
        if (w_accept) begin
          w_main_d  = w_in_entry;
          w_state_d = StOne;
        end
      end
      StOne: begin
        if (w_accept && out_ready) begin
          w_main_d = w_in_entry;
        end else if (w_accept) begin
          w_skid_d  = w_in_entry;
          w_state_d = StTwo;
        end else if (out_ready) begin
          w_state_d = StEmpty;
        end
      end
      StTwo: begin
        if (out_ready) begin
          w_main_d  = r_skid;
          w_state_d = StOne;
        end
      end
      default: w_state_d = StEmpty;
    endcase
    // Flush overrides any accept or drain this cycle; held data is left stale.
    if (flush) begin
      w_state_d = StEmpty;
    end
    w_in_ready_d = (w_state_d != StTwo);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StEmpty;
      r_main     <= ENTRY_RESET;
      r_skid     <= ENTRY_RESET;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_main     <= w_main_d;
      r_skid     <= w_skid_d;
      r_in_ready <= w_in_ready_d;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != StEmpty);
  assign out_a       = r_main.a[XLEN-1:0];
  assign out_shamt   = r_main.shamt[SW-1:0];
  assign out_type    = r_main.shtype;
  assign out_rd      = r_main.rd;
  assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage (XLEN=32): directed steps followed by
// randomized traffic, checked against a queue-based model of the two-entry stage.
module tb_shift_issue_stage;

  localparam int XLEN = 32;
  localparam int SW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [11:0]     in_imm;
  logic            in_is_imm;
  logic [2:0]      in_funct3;
  logic            in_funct7b5;
  logic [4:0]      in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [SW-1:0]   out_shamt;
  logic [1:0]      out_type;
  logic [4:0]      out_rd;
  logic            out_illegal;

  always #5 clk = ~clk;

  shift_issue_stage #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .in_is_imm   (in_is_imm),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_shamt   (out_shamt),
    .out_type    (out_type),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  typedef struct {
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t       q[$];       // entries held by the stage, oldest first
  logic [4:0] seen_rd[$]; // rd of every completed output transfer
  bit         m_ready;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected entry from the instruction rules, using the current inputs.
  function automatic exp_t ref_of();
    exp_t e;
    int   amt;
    bit   ok_f3;
    amt   = in_is_imm ? int'(in_imm) : int'(in_rs2 % 32);
    ok_f3 = (in_funct3 == 3'd1) || (in_funct3 == 3'd5);
    e.a     = in_rs1;
    e.shamt = 5'(amt % 32);
    e.typ   = !ok_f3 ? 2'd1 : (in_funct3 == 3'd1) ? 2'd1 : (in_funct7b5 ? 2'd2 : 2'd0);
    e.ill   = !ok_f3 || (in_is_imm && (((in_imm & 12'h3FF) >= 12'd32) ||
                                       (in_funct3 == 3'd1 && in_funct7b5)));
    e.rd    = in_rd;
    return e;
  endfunction

  // Check outputs against the model, then advance model and DUT one clock.
  task automatic cycle(output bit acc);
    exp_t e;
    bit   pop;
    check("out_valid", out_valid, q.size() > 0);
    check("in_ready", in_ready, m_ready);
    if (q.size() > 0) begin
      check("out_a", out_a, q[0].a);
      check("out_shamt", out_shamt, q[0].shamt);
      check("out_type", out_type, q[0].typ);
      check("out_rd", out_rd, q[0].rd);
      check("out_illegal", out_illegal, q[0].ill);
    end
    e   = ref_of();
    acc = in_valid && m_ready && !flush;
    pop = (q.size() > 0) && out_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (pop) begin
        seen_rd.push_back(q[0].rd);
        void'(q.pop_front());
      end
      if (acc) q.push_back(e);
    end
    m_ready = q.size() < 2;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic [31:0] rs1, input logic [31:0] rs2, input logic [11:0] imm,
                        input logic is_imm, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd);
    in_valid    = 1'b1;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_imm      = imm;
    in_is_imm   = is_imm;
    in_funct3   = f3;
    in_funct7b5 = f7;
    in_rd       = rd;
  endtask

  task automatic set_random(input logic [4:0] rd);
    logic [2:0]  f3;
    logic [11:0] imm;
    logic        f7;
    f7  = 1'($urandom_range(0, 1));
    f3  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : ($urandom_range(0, 1) ? 3'd1 : 3'd5);
    imm = ($urandom_range(0, 3) == 0) ? 12'($urandom) : {1'b0, f7, 5'd0, 5'($urandom)};
    set_in($urandom, $urandom, imm, 1'($urandom_range(0, 1)), f3, f7, rd);
  endtask

  task automatic hit_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_type", out_type, 2'd1);
    check("rst_out_a", out_a, 32'd0);
    check("rst_in_ready", in_ready, 1'b0);
    q.delete();
    m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    int n_acc;
    int n31;
    logic [4:0] rd_next;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_is_imm = 1'b0;
    in_funct3 = 3'd1; in_funct7b5 = 1'b0; in_rd = '0;
    m_ready = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_type", out_type, 2'd1);
    check("reset_out_shamt", out_shamt, 5'd0);
    check("reset_out_rd", out_rd, 5'd0);
    check("reset_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cycle(acc);  // in_ready still 0 here, rises after this edge
    check("ready_after_release", in_ready, 1'b1);

    // SRAI
    out_ready = 1'b1;
    set_in(32'h8000_0010, $urandom, 12'h403, 1'b1, 3'b101, 1'b1, 5'd9);
    cycle(acc);
    in_valid = 1'b0;
    check("srai_a", out_a, 32'h8000_0010);
    check("srai_shamt", out_shamt, 5'd3);
    check("srai_type", out_type, 2'd2);
    check("srai_illegal", out_illegal, 1'b0);
    cycle(acc);

    // SLL register form: upper rs2 bits ignored
    set_in($urandom, 32'hFFFF_FFE7, 12'($urandom), 1'b0, 3'b001, 1'b0, 5'd2);
    cycle(acc);
    in_valid = 1'b0;
    check("sll_shamt", out_shamt, 5'd7);
    check("sll_type", out_type, 2'd1);
    check("sll_illegal", out_illegal, 1'b0);
    cycle(acc);

    // SLLI with shamt bit 5 set is illegal on RV32
    set_in($urandom, $urandom, 12'h020, 1'b1, 3'b001, 1'b0, 5'd3);
    cycle(acc);
    in_valid = 1'b0;
    check("slli_illegal", out_illegal, 1'b1);
    check("slli_type", out_type, 2'd1);
    cycle(acc);

    // Backpressure: four inputs, out_ready low for three cycles
    seen_rd.delete();
    rd_next = 5'd1;
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (rd_next <= 5'd4) set_random(rd_next);
      else in_valid = 1'b0;
      out_ready = (i >= 3);
      if (i == 2) begin
        check("bp_two_accepts", n_acc, 2);
        check("bp_in_ready_drop", in_ready, 1'b0);
      end
      cycle(acc);
      if (acc) begin
        rd_next++;
        n_acc++;
      end
    end
    check("bp_count", seen_rd.size(), 4);
    for (int i = 0; i < 4 && i < seen_rd.size(); i++) check("bp_order", seen_rd[i], i + 1);

    // Streaming: ten back-to-back transfers
    seen_rd.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i < 10) set_random(5'(i));
      else in_valid = 1'b0;
      if (i > 0) check("stream_out_valid", out_valid, 1'b1);
      check("stream_in_ready", in_ready, 1'b1);
      cycle(acc);
    end
    check("stream_count", seen_rd.size(), 10);

    // Flush while holding two entries, with an input offered in the flush cycle
    seen_rd.delete();
    out_ready = 1'b0;
    set_random(5'd10);
    cycle(acc);
    set_random(5'd11);
    cycle(acc);
    check("pre_flush_full", in_ready, 1'b0);
    set_random(5'd31);
    flush = 1'b1;
    cycle(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle(acc);
    check("flush_no_output", seen_rd.size(), 0);

    // Flush in ONE with an accepted handshake that must be discarded
    set_random(5'd20);
    cycle(acc);
    set_random(5'd31);
    out_ready = 1'b0;
    flush = 1'b1;
    cycle(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle(acc);
    n31 = 0;
    foreach (seen_rd[i]) if (seen_rd[i] == 5'd31) n31++;
    check("flushed_input_absent", n31, 0);

    // Randomized traffic with a reset landing mid-stream
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        out_ready = 1'b0;
        set_random(5'($urandom));
        cycle(acc);
        cycle(acc);
        hit_reset();
        in_valid = 1'b0;
        cycle(acc);
        check("ready_after_mid_reset", in_ready, 1'b1);
      end
      if ($urandom_range(0, 3) != 0) set_random(5'($urandom));
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 24) == 0);
      cycle(acc);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle(acc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
